pe_net_feeder: RTL and testbench

//  Upstream sequencer for the PE array. Per job it loads kernel weights into the array
//  (w_conf/w_in shift chain), then issues the one-cycle control config (cntl_conf with

---
 rtl/pe_net_feeder.sv | 139 +++++++++++++
 tb/tb_pe_net_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_net_feeder.sv
// Job sequencer for the PE array: shifts in kernel weights, strobes the control
// config, streams one frame column by column, then waits out the drain time.
module pe_net_feeder #(
  parameter int unsigned ROW_SIZE = 4,
  parameter int unsigned N        = 4,
  parameter int unsigned M        = 2,
  parameter int unsigned CL_IN    = 4,
  parameter int unsigned CL1      = 2,
  parameter int unsigned LINES    = 16,
  parameter int unsigned KW       = 9,
  parameter int unsigned DRAIN    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      skip_cfg,
  input  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch,
  input  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch,
  input  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src,
  input  logic [ROW_SIZE*M-1:0]     w_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [ROW_SIZE*N-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [ROW_SIZE*N-1:0]     d_in,
  output logic [ROW_SIZE-1:0]       en_in,
  output logic [ROW_SIZE*M-1:0]     w_in,
  output logic                      w_conf,
  output logic                      cntl_conf,
  output logic [ROW_SIZE*CL_IN-1:0] d_ch_in,
  output logic [ROW_SIZE*CL_IN-1:0] bp_ch_in,
  output logic [ROW_SIZE*CL1-1:0]   bp_src_in,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WCW = $clog2(KW + 1);
  localparam int unsigned CCW = $clog2(LINES + 1);
  localparam int unsigned DCW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_CCONF, S_STREAM, S_DRAIN} state_t;

  state_t         state;
  logic [WCW-1:0] w_cnt;
  logic [CCW-1:0] c_cnt;
  logic [DCW-1:0] d_cnt;
  logic           w_acc;
  logic           s_acc;

  // Handshakes use the registered ready flags, which are only set in their own state.
  assign w_acc = w_valid & w_ready;
  assign s_acc = s_valid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      w_cnt     <= '0;
      c_cnt     <= '0;
      d_cnt     <= '0;
      w_ready   <= 1'b0;
      s_ready   <= 1'b0;
      d_in      <= '0;
      en_in     <= '0;
      w_in      <= '0;
      w_conf    <= 1'b0;
      cntl_conf <= 1'b0;
      d_ch_in   <= '0;
      bp_ch_in  <= '0;
      bp_src_in <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      w_conf    <= w_acc;
      en_in     <= {ROW_SIZE{s_acc}};
      cntl_conf <= 1'b0;
      done      <= 1'b0;
      if (w_acc) w_in <= w_data;
      if (s_acc) d_in <= s_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            d_ch_in   <= cfg_d_ch;
            bp_ch_in  <= cfg_bp_ch;
            bp_src_in <= cfg_bp_src;
            busy      <= 1'b1;
            if (skip_cfg) begin
              state   <= S_STREAM;
              s_ready <= 1'b1;
            end else begin
              state   <= S_WLOAD;
              w_ready <= 1'b1;
            end
          end
        end
        S_WLOAD: begin
          if (w_acc) begin
            if (w_cnt == WCW'(KW - 1)) begin
              w_cnt     <= '0;
              w_ready   <= 1'b0;
              cntl_conf <= 1'b1;
              state     <= S_CCONF;
            end else begin
              w_cnt <= w_cnt + WCW'(1);
            end
          end
        end
        S_CCONF: begin
          state   <= S_STREAM;
          s_ready <= 1'b1;
        end
        S_STREAM: begin
          if (s_acc) begin
            if (c_cnt == CCW'(LINES - 1)) begin
              c_cnt   <= '0;
              s_ready <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              c_cnt <= c_cnt + CCW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (d_cnt == DCW'(DRAIN - 1)) begin
            d_cnt <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            d_cnt <= d_cnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_net_feeder.sv
// Directed bench for pe_net_feeder: reset abort, full job, handshake gaps,
// skipped configuration and ignored start / extra column.
module tb_pe_net_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        skip_cfg;
  logic [15:0] cfg_d_ch;
  logic [15:0] cfg_bp_ch;
  logic [7:0]  cfg_bp_src;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] d_in;
  logic [3:0]  en_in;
  logic [7:0]  w_in;
  logic        w_conf;
  logic        cntl_conf;
  logic [15:0] d_ch_in;
  logic [15:0] bp_ch_in;
  logic [7:0]  bp_src_in;
  logic        busy;
  logic        done;

  pe_net_feeder dut (
    .clk(clk), .rst(rst), .start(start), .skip_cfg(skip_cfg),
    .cfg_d_ch(cfg_d_ch), .cfg_bp_ch(cfg_bp_ch), .cfg_bp_src(cfg_bp_src),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .d_in(d_in), .en_in(en_in), .w_in(w_in), .w_conf(w_conf), .cntl_conf(cntl_conf),
    .d_ch_in(d_ch_in), .bp_ch_in(bp_ch_in), .bp_src_in(bp_src_in),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  // Expected held values of the registered data outputs.
  logic [15:0] d_exp = '0;
  logic [7:0]  w_exp = '0;

  // Observations collected by run_job, judged by each test task.
  int o_wconf_n, o_wconf_first, o_wconf_last, o_cc_n, o_cc_cyc;
  int o_en_beats, o_acc_n, o_done_n, o_done_cyc, o_first_acc, o_first_sready;
  int o_last_acc_cyc, o_en_err, o_d_err, o_w_err, o_busy_drop, o_timeout;
  logic o_sready_after, o_busy_after;
  logic [15:0] o_cc_dch, o_cc_bpch;
  logic [7:0]  o_cc_bps;

  function automatic logic [15:0] col_val(input int j);
    return 16'((j + 1) * 16'h0F3B);
  endfunction

  task automatic run_job(input logic skip, input logic wgap, input logic sgap,
                         input logic extra, input logic poke,
                         input logic [15:0] dch, input logic [15:0] bpch, input logic [7:0] bps);
    logic wpend, spend;
    int wi, sj, cyc;
    o_wconf_n = 0; o_wconf_first = -1; o_wconf_last = -1; o_cc_n = 0; o_cc_cyc = -1;
    o_en_beats = 0; o_acc_n = 0; o_done_n = 0; o_done_cyc = -1; o_first_acc = -1;
    o_first_sready = -1; o_last_acc_cyc = -10; o_en_err = 0; o_d_err = 0; o_w_err = 0;
    o_busy_drop = 0; o_timeout = 0; o_sready_after = 1'b1;
    o_cc_dch = '0; o_cc_bpch = '0; o_cc_bps = '0;
    wpend = 1'b0; spend = 1'b0; wi = 0; sj = 0; cyc = 0;
    @(negedge clk);
    cfg_d_ch = dch; cfg_bp_ch = bpch; cfg_bp_src = bps;
    start = 1'b1; skip_cfg = skip;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (t == 0) begin
        cfg_d_ch = ~dch; cfg_bp_ch = ~bpch; cfg_bp_src = ~bps;
      end
      if (w_conf) begin
        o_wconf_n++;
        if (o_wconf_first < 0) o_wconf_first = cyc;
        o_wconf_last = cyc;
      end
      if (w_conf !== wpend) o_w_err++;
      if (w_in !== w_exp) o_w_err++;
      if (en_in !== (spend ? 4'hF : 4'h0)) o_en_err++;
      if (d_in !== d_exp) o_d_err++;
      if (en_in == 4'hF) o_en_beats++;
      if (cyc == o_last_acc_cyc + 1) o_sready_after = s_ready;
      if (cntl_conf) begin
        o_cc_n++; o_cc_cyc = cyc;
        o_cc_dch = d_ch_in; o_cc_bpch = bp_ch_in; o_cc_bps = bp_src_in;
      end
      if (s_ready && o_first_sready < 0) o_first_sready = cyc;
      if (done) begin
        o_done_n++; o_done_cyc = cyc;
      end else if (!busy && o_done_n == 0) begin
        o_busy_drop++;
      end
      if (o_done_n > 0) break;
      w_valid = (wi < 9) && (wgap ? (t % 2 == 0) : 1'b1);
      w_data  = 8'(wi + 1);
      s_valid = (sj < 16 || extra) && (sgap ? (t % 2 == 1) : 1'b1);
      s_data  = col_val(sj);
      wpend = w_valid && w_ready;
      if (wpend) begin
        w_exp = w_data; wi++;
      end
      spend = s_valid && s_ready;
      if (spend) begin
        d_exp = s_data; sj++; o_acc_n++;
        if (o_first_acc < 0) o_first_acc = cyc;
        if (sj == 16) o_last_acc_cyc = cyc;
      end
      start = poke && (sj > 0);
    end
    if (o_done_n == 0) o_timeout = 1;
    start = 1'b0; w_valid = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    o_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; skip_cfg = 1'b0; w_valid = 1'b0; s_valid = 1'b0;
    cfg_d_ch = '0; cfg_bp_ch = '0; cfg_bp_src = '0; w_data = '0; s_data = '0;
    repeat (3) @(negedge clk);
    vec++; if ({busy, done, w_ready, s_ready, w_conf, cntl_conf} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, w_ready, s_ready, w_conf, cntl_conf});
    end
    vec++; if ({d_in, en_in, w_in, d_ch_in, bp_ch_in, bp_src_in} !== '0) begin
      errs++; $display("FAIL reset_data: got %h want 0", {d_in, en_in, w_in, d_ch_in, bp_ch_in, bp_src_in});
    end
    rst = 1'b0;
    @(negedge clk);
    cfg_d_ch = 16'h1357; cfg_bp_ch = 16'h2468; cfg_bp_src = 8'h5A;
    start = 1'b1; skip_cfg = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
    repeat (3) @(negedge clk);
    vec++; if ({busy, en_in} !== 5'h1F) begin
      errs++; $display("FAIL reset_pre_stream: got %h want 1f", {busy, en_in});
    end
    #2 rst = 1'b1;
    #1;
    vec++; if ({busy, done, s_ready, en_in} !== 7'b0) begin
      errs++; $display("FAIL reset_async_ctrl: got %b want 0", {busy, done, s_ready, en_in});
    end
    vec++; if ({d_in, d_ch_in, bp_ch_in, bp_src_in} !== '0) begin
      errs++; $display("FAIL reset_async_data: got %h want 0", {d_in, d_ch_in, bp_ch_in, bp_src_in});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; skip_cfg = 1'b0;
    begin
      int seen_done, seen_busy;
      seen_done = 0; seen_busy = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen_done++;
        if (busy) seen_busy++;
      end
      vec++; if (seen_done != 0) begin
        errs++; $display("FAIL reset_no_done: got %0d done pulses want 0", seen_done);
      end
      vec++; if (seen_busy != 0) begin
        errs++; $display("FAIL reset_stays_idle: got %0d busy cycles want 0", seen_busy);
      end
    end
    d_exp = '0; w_exp = '0;
  endtask

  task automatic test_full_job();
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 16'h0F0F, 8'h6C);
    vec++; if (o_timeout != 0) begin
      errs++; $display("FAIL full_timeout: got no done want done"); end
    vec++; if (o_wconf_n != 9 || o_wconf_last - o_wconf_first != 8) begin
      errs++; $display("FAIL full_wconf: got %0d cycles span %0d want 9 span 8", o_wconf_n, o_wconf_last - o_wconf_first); end
    vec++; if (o_w_err != 0) begin
      errs++; $display("FAIL full_w_in: got %0d bad cycles want 0", o_w_err); end
    vec++; if (o_cc_n != 1 || o_cc_cyc < o_wconf_first + 8) begin
      errs++; $display("FAIL full_cntl_conf: got %0d pulses at %0d want 1 after weights", o_cc_n, o_cc_cyc); end
    vec++; if ({o_cc_dch, o_cc_bpch, o_cc_bps} !== {16'hA5C3, 16'h0F0F, 8'h6C}) begin
      errs++; $display("FAIL full_masks: got %h want a5c30f0f6c", {o_cc_dch, o_cc_bpch, o_cc_bps}); end
    vec++; if (o_first_sready != o_cc_cyc + 1) begin
      errs++; $display("FAIL full_stream_start: got %0d want %0d", o_first_sready, o_cc_cyc + 1); end
    vec++; if (o_en_beats != 16 || o_en_err != 0 || o_d_err != 0) begin
      errs++; $display("FAIL full_stream: got beats %0d en_err %0d d_err %0d want 16 0 0", o_en_beats, o_en_err, o_d_err); end
    vec++; if (o_done_cyc - o_first_acc != 24) begin
      errs++; $display("FAIL full_done_latency: got %0d want 24", o_done_cyc - o_first_acc); end
    vec++; if (o_busy_drop != 0 || o_busy_after !== 1'b0) begin
      errs++; $display("FAIL full_busy: got drops %0d after %b want 0 0", o_busy_drop, o_busy_after); end
  endtask

  task automatic test_gaps();
    run_job(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h8000, 8'h01);
    vec++; if (o_timeout != 0 || o_done_n != 1) begin
      errs++; $display("FAIL gaps_done: got %0d pulses want 1", o_done_n); end
    vec++; if (o_wconf_n != 9 || o_w_err != 0) begin
      errs++; $display("FAIL gaps_wconf: got %0d cycles w_err %0d want 9 0", o_wconf_n, o_w_err); end
    vec++; if (o_wconf_last - o_wconf_first <= 8) begin
      errs++; $display("FAIL gaps_stretch: got span %0d want > 8", o_wconf_last - o_wconf_first); end
    vec++; if (o_en_beats != 16 || o_en_err != 0) begin
      errs++; $display("FAIL gaps_en: got beats %0d en_err %0d want 16 0", o_en_beats, o_en_err); end
    vec++; if (o_d_err != 0) begin
      errs++; $display("FAIL gaps_d_hold: got %0d bad cycles want 0", o_d_err); end
  endtask

  task automatic test_skip_cfg();
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C5A, 16'hF0F1, 8'h93);
    vec++; if (o_timeout != 0 || o_done_n != 1) begin
      errs++; $display("FAIL skip_done: got %0d pulses want 1", o_done_n); end
    vec++; if (o_wconf_n != 0 || o_cc_n != 0) begin
      errs++; $display("FAIL skip_no_cfg: got wconf %0d cntl %0d want 0 0", o_wconf_n, o_cc_n); end
    vec++; if (o_first_sready != 1) begin
      errs++; $display("FAIL skip_stream_start: got cycle %0d want 1", o_first_sready); end
    vec++; if ({d_ch_in, bp_ch_in, bp_src_in} !== {16'h3C5A, 16'hF0F1, 8'h93}) begin
      errs++; $display("FAIL skip_masks: got %h want 3c5af0f193", {d_ch_in, bp_ch_in, bp_src_in}); end
    vec++; if (o_en_beats != 16 || o_en_err != 0 || o_d_err != 0) begin
      errs++; $display("FAIL skip_stream: got beats %0d en_err %0d d_err %0d want 16 0 0", o_en_beats, o_en_err, o_d_err); end
  endtask

  task automatic test_ignore_start();
    run_job(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7E81, 16'h1111, 8'h22);
    vec++; if (o_timeout != 0 || o_done_n != 1) begin
      errs++; $display("FAIL ignore_done: got %0d pulses want 1", o_done_n); end
    vec++; if (o_busy_drop != 0) begin
      errs++; $display("FAIL ignore_busy: got %0d idle cycles want 0", o_busy_drop); end
    vec++; if (o_acc_n != 16) begin
      errs++; $display("FAIL ignore_extra_col: got %0d accepts want 16", o_acc_n); end
    vec++; if (o_sready_after !== 1'b0) begin
      errs++; $display("FAIL ignore_sready_drop: got %b want 0", o_sready_after); end
    vec++; if (o_en_beats != 16) begin
      errs++; $display("FAIL ignore_beats: got %0d want 16", o_en_beats); end
    vec++; if (o_busy_after !== 1'b0) begin
      errs++; $display("FAIL ignore_no_restart: got busy %b want 0", o_busy_after); end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_gaps();
    test_skip_cfg();
    test_ignore_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
